uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  UART receive side; pairs with the UART transmitter. Samples serial rxd with a programmable bit period,
//  recovers 8 data bits LSB-first, checks optional parity and 1 or 2 stop bits.
//  Presents each byte with a one-cycle valid strobe and per-frame error flags to the uart_controller host logic.
// PARAMETERS
//  SYNC_STAGES  2  rxd metastability flops before any logic (>=2)
// PORTS
//  n_reset     in   1   asynchronous reset, active-low
//  mclk        in   1   system clock
//  baudrate    in   16  bit period minus 1, in mclk cycles (same encoding as the transmitter)
//  parity_sel  in   2   0: none, 1: even, 2/3: odd
//  stop_sel    in   1   0: 1 stop bit, 1: 2 stop bits
//  rxd         in   1   serial input, idle high, asynchronous to mclk
//  rdata       out  8   last received byte; held until the next frame completes
//  rx_valid    out  1   1-cycle pulse: rdata, parity_err and frame_err updated
//  parity_err  out  1   parity mismatch on the last frame; forced 0 when parity_sel==0
//  frame_err   out  1   any configured stop bit sampled low on the last frame
//  busy        out  1   high from start-edge detection until return to IDLE
// BEHAVIOUR
//  Reset: rdata=0, rx_valid=0, parity_err=0, frame_err=0, busy=0, FSM=IDLE, sync flops preset to 1.
//  All logic uses rxd_s, the SYNC_STAGES-synchronized rxd. Input latency is SYNC_STAGES cycles.
//  Bit period: P = baudrate+1 cycles. cnt1 runs 0..baudrate, then wraps to 0; each wrap advances the bit index.
//  Mid-bit sample point: cnt1 == baudrate>>1. Only rxd_s at this instant is used.
//  FSM states:
//   IDLE   - on rxd_s 1->0 edge: cnt1=0, go to START, busy=1.
//   START  - at mid-bit, rxd_s==1 is a glitch: go to IDLE, no rx_valid, no flag change.
//            At mid-bit, rxd_s==0: go to DATA at the next bit boundary.
//   DATA   - 8 bits; the mid-bit sample shifts into shreg[7] (right shift), so bit0 lands in shreg[0].
//            After bit 7: go to PARITY if parity_sel!=0, else STOP.
//   PARITY - mid-bit sample captured as pbit.
//            expected = ^shreg for sel==1; ~^shreg for sel 2 or 3.
//   STOP   - one stop bit (stop_sel=0) or two (stop_sel=1). Each is sampled at mid-bit;
//            frame_err_acc |= ~rxd_s. At the mid-bit sample of the LAST stop bit:
//            the next cycle loads rdata=shreg, parity_err=(pbit!=expected)&(sel!=0), frame_err=frame_err_acc,
//            pulses rx_valid for 1 cycle, and returns to IDLE (busy=0).
//  Returning at mid-stop lets a back-to-back start edge (half a bit later) be caught. Tx-to-rx byte latency is
//  ~(frame bits - 0.5)*P + SYNC_STAGES + 1 cycles.
//  Break / low stop: a low stop bit still completes the frame with frame_err=1.
//   IDLE then re-arms only after rxd_s has been seen high, so a held-low line yields no repeated frames.
//  parity_sel, stop_sel and baudrate are sampled once at start-edge detection and held for the frame.
//   Changes mid-frame take effect on the next frame.
//  baudrate<2 is unsupported; behaviour is undefined but the block must not lock up (FSM always reaches IDLE).
//  Error flags are not sticky: each rx_valid overwrites them.
//  n_reset low mid-frame: immediate return to reset values, no rx_valid.
// STRUCTURE
//  Shared uart_defs.vh: PAR_NONE/PAR_EVEN/PAR_ODD, STOP_1/STOP_2, FSM state encodings (common with the transmitter).
//  One sub-module: uart_bit_timer. It holds cnt1 and emits mid_tick and end_tick, given baudrate and a
//   restart strobe. It is reusable by the transmitter.
//  Remainder (synchronizer, FSM, shift register, error logic) stays in uart_rx. Target ~200 lines.
// TESTING
//  baudrate=15, parity none, 1 stop, byte 0xA5 -> one rx_valid, rdata=0xA5, both errors 0, busy low afterwards.
//  parity_sel=1, byte 0x03 with parity bit 0 -> parity_err=0.
//   Same byte with parity bit 1 -> parity_err=1, rdata=0x03.
//  parity_sel=2, stop_sel=1, byte 0x80, second stop bit driven low -> frame_err=1, rdata=0x80, parity_err=0.
//  rxd low pulse of 5 cycles (less than P/2) at baudrate=15 -> no rx_valid, busy back to 0, rdata unchanged.
//  Back-to-back frames from the transmitter: 0x00 then 0xFF, no idle gap, baudrate=7 -> two rx_valid pulses,
//   correct bytes. Then rxd held low for 3 frame times -> exactly one frame_err frame, no further rx_valid.
//  Assert n_reset during DATA bit 4 -> outputs at reset values. A following clean frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: parity/stop encodings, receiver FSM states and
// the parity helper used by both directions of the link.
package uart_rx_pkg;

   localparam logic [1:0] PAR_NONE = 2'd0;
   localparam logic [1:0] PAR_EVEN = 2'd1;
   localparam logic [1:0] PAR_ODD  = 2'd2;
   localparam logic       STOP_1   = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_e;

   // Parity bit a transmitter would send for this byte; encoding 3 aliases odd.
   function automatic logic par_expected(input logic [1:0] sel, input logic [7:0] data);
      logic res;
      case (sel)
         PAR_EVEN:       res = ^data;
         PAR_ODD, 2'd3:  res = ~^data;
         default:        res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter shared by UART rx/tx: counts 0..baud and flags the
// mid-bit and end-of-bit cycles; restart_i forces the count back to zero.
module uart_bit_timer (
   input  logic        n_reset,
   input  logic        mclk,
   input  logic [15:0] baud_i,
   input  logic        restart_i,
   output logic        mid_tick_o,
   output logic        end_tick_o
);

   logic [15:0] cnt_q;

   // Free-running period counter, re-phased by restart_i.
   always_ff @(posedge mclk or negedge n_reset) begin
      if (!n_reset) begin
         cnt_q <= 16'd0;
      end else if (restart_i) begin
         cnt_q <= 16'd0;
      end else if (cnt_q >= baud_i) begin
         cnt_q <= 16'd0;
      end else begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

   assign mid_tick_o = (cnt_q == (baud_i >> 1));
   assign end_tick_o = (cnt_q >= baud_i);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes rxd, samples each bit at mid-period, checks
// optional parity and 1/2 stop bits, and strobes each received byte out.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic        n_reset,
   input  logic        mclk,
   input  logic [15:0] baudrate,
   input  logic [1:0]  parity_sel,
   input  logic        stop_sel,
   input  logic        rxd,
   output logic [7:0]  rdata,
   output logic        rx_valid,
   output logic        parity_err,
   output logic        frame_err,
   output logic        busy
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxd_s;
   logic                   rxd_prev_q;
   logic                   fall_s;
   logic                   restart_s;
   logic                   mid_tick_s;
   logic                   end_tick_s;
   logic                   last_stop_s;

   rx_state_e   state_q;
   logic [15:0] baud_q;
   logic [1:0]  par_q;
   logic        stop_sel_q;
   logic [2:0]  bit_idx_q;
   logic        stop_idx_q;
   logic [7:0]  shreg_q;
   logic        pbit_q;
   logic        ferr_acc_q;
   logic [7:0]  rdata_q;
   logic        rx_valid_q;
   logic        parity_err_q;
   logic        frame_err_q;
   logic        busy_q;

   // Metastability chain, preset to the idle-high line level.
   always_ff @(posedge mclk or negedge n_reset) begin
      if (!n_reset) begin
         sync_q     <= '1;
         rxd_prev_q <= 1'b1;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], rxd};
         rxd_prev_q <= rxd_s;
      end
   end

   assign rxd_s       = sync_q[SYNC_STAGES-1];
   // A line held low never produces a new edge, so a break cannot retrigger.
   assign fall_s      = rxd_prev_q & ~rxd_s;
   assign restart_s   = (state_q == ST_IDLE) & fall_s;
   assign last_stop_s = (stop_sel_q == STOP_1) | stop_idx_q;

   uart_bit_timer u_timer (
      .n_reset    (n_reset),
      .mclk       (mclk),
      .baud_i     (baud_q),
      .restart_i  (restart_s),
      .mid_tick_o (mid_tick_s),
      .end_tick_o (end_tick_s)
   );

   // Frame FSM, shift register and registered result/flag outputs.
   always_ff @(posedge mclk or negedge n_reset) begin
      if (!n_reset) begin
         state_q      <= ST_IDLE;
         baud_q       <= 16'd0;
         par_q        <= PAR_NONE;
         stop_sel_q   <= STOP_1;
         bit_idx_q    <= 3'd0;
         stop_idx_q   <= 1'b0;
         shreg_q      <= 8'd0;
         pbit_q       <= 1'b0;
         ferr_acc_q   <= 1'b0;
         rdata_q      <= 8'd0;
         rx_valid_q   <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (fall_s) begin
                  state_q    <= ST_START;
                  busy_q     <= 1'b1;
                  baud_q     <= baudrate;
                  par_q      <= parity_sel;
                  stop_sel_q <= stop_sel;
                  bit_idx_q  <= 3'd0;
                  stop_idx_q <= 1'b0;
                  ferr_acc_q <= 1'b0;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_START: begin
               if (mid_tick_s && rxd_s) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else if (end_tick_s) begin
                  state_q <= ST_DATA;
               end else begin
                  state_q <= ST_START;
               end
            end
            ST_DATA: begin
               if (mid_tick_s) begin
                  shreg_q <= {rxd_s, shreg_q[7:1]};
               end else begin
                  shreg_q <= shreg_q;
               end
               if (end_tick_s) begin
                  bit_idx_q <= bit_idx_q + 3'd1;
                  if (bit_idx_q == 3'd7) begin
                     state_q <= (par_q != PAR_NONE) ? ST_PARITY : ST_STOP;
                  end else begin
                     state_q <= ST_DATA;
                  end
               end else begin
                  state_q <= ST_DATA;
               end
            end
            ST_PARITY: begin
               if (mid_tick_s) begin
                  pbit_q <= rxd_s;
               end else begin
                  pbit_q <= pbit_q;
               end
               if (end_tick_s) begin
                  state_q <= ST_STOP;
               end else begin
                  state_q <= ST_PARITY;
               end
            end
            ST_STOP: begin
               // Finish at mid-stop so a back-to-back start edge is not missed.
               if (mid_tick_s && last_stop_s) begin
                  state_q      <= ST_IDLE;
                  busy_q       <= 1'b0;
                  rdata_q      <= shreg_q;
                  rx_valid_q   <= 1'b1;
                  parity_err_q <= (pbit_q != par_expected(par_q, shreg_q)) & (par_q != PAR_NONE);
                  frame_err_q  <= ferr_acc_q | ~rxd_s;
               end else if (mid_tick_s) begin
                  ferr_acc_q <= ferr_acc_q | ~rxd_s;
                  state_q    <= ST_STOP;
               end else if (end_tick_s) begin
                  stop_idx_q <= 1'b1;
                  state_q    <= ST_STOP;
               end else begin
                  state_q <= ST_STOP;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign rdata      = rdata_q;
   assign rx_valid   = rx_valid_q;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: drives hand-built serial frames and checks the
// captured bytes and flags against hand-computed values.
module tb_uart_rx;

   logic        mclk = 1'b0;
   logic        n_reset = 1'b0;
   logic [15:0] baudrate = 16'd15;
   logic [1:0]  parity_sel = 2'd0;
   logic        stop_sel = 1'b0;
   logic        rxd = 1'b1;
   logic [7:0]  rdata;
   logic        rx_valid;
   logic        parity_err;
   logic        frame_err;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int vcnt   = 0;
   int v0;
   logic [7:0] log_data [0:31];
   logic       log_perr [0:31];
   logic       log_ferr [0:31];

   uart_rx dut (
      .n_reset    (n_reset),
      .mclk       (mclk),
      .baudrate   (baudrate),
      .parity_sel (parity_sel),
      .stop_sel   (stop_sel),
      .rxd        (rxd),
      .rdata      (rdata),
      .rx_valid   (rx_valid),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   always #5 mclk = ~mclk;

   // Record every strobed result on the falling edge.
   always @(negedge mclk) begin
      if (rx_valid === 1'b1) begin
         if (vcnt < 32) begin
            log_data[vcnt] = rdata;
            log_perr[vcnt] = parity_err;
            log_ferr[vcnt] = frame_err;
         end
         vcnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_bit(input logic v);
      rxd = v;
      repeat (int'(baudrate) + 1) @(negedge mclk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic use_par, input logic pbit,
                             input logic stop_last);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      if (use_par) drive_bit(pbit);
      if (stop_sel) drive_bit(1'b1);
      drive_bit(stop_last);
      rxd = 1'b1;
   endtask

   initial begin
      repeat (3) @(negedge mclk);
      check("rst_rdata", {24'd0, rdata}, 32'h0);
      check("rst_valid", {31'd0, rx_valid}, 32'h0);
      check("rst_perr", {31'd0, parity_err}, 32'h0);
      check("rst_ferr", {31'd0, frame_err}, 32'h0);
      check("rst_busy", {31'd0, busy}, 32'h0);
      n_reset = 1'b1;
      repeat (5) @(negedge mclk);

      // Plain 8N1 frame.
      v0 = vcnt;
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
      repeat (20) @(negedge mclk);
      check("a5_count", vcnt - v0, 32'd1);
      check("a5_data", {24'd0, log_data[v0]}, 32'hA5);
      check("a5_perr", {31'd0, log_perr[v0]}, 32'h0);
      check("a5_ferr", {31'd0, log_ferr[v0]}, 32'h0);
      check("a5_busy", {31'd0, busy}, 32'h0);

      // Even parity: 0x03 has even weight, so parity bit 0 is correct.
      parity_sel = 2'd1;
      v0 = vcnt;
      send_frame(8'h03, 1'b1, 1'b0, 1'b1);
      send_frame(8'h03, 1'b1, 1'b1, 1'b1);
      repeat (20) @(negedge mclk);
      check("even_count", vcnt - v0, 32'd2);
      check("even_ok_perr", {31'd0, log_perr[v0]}, 32'h0);
      check("even_bad_perr", {31'd0, log_perr[v0+1]}, 32'h1);
      check("even_bad_data", {24'd0, log_data[v0+1]}, 32'h03);

      // Odd parity, two stop bits, second stop low.
      parity_sel = 2'd2;
      stop_sel   = 1'b1;
      v0 = vcnt;
      send_frame(8'h80, 1'b1, 1'b0, 1'b0);
      repeat (20) @(negedge mclk);
      check("odd_count", vcnt - v0, 32'd1);
      check("odd_data", {24'd0, log_data[v0]}, 32'h80);
      check("odd_ferr", {31'd0, log_ferr[v0]}, 32'h1);
      check("odd_perr", {31'd0, log_perr[v0]}, 32'h0);

      // Short low glitch is rejected at the start-bit mid sample.
      parity_sel = 2'd0;
      stop_sel   = 1'b0;
      v0 = vcnt;
      rxd = 1'b0;
      repeat (5) @(negedge mclk);
      check("glitch_busy_hi", {31'd0, busy}, 32'h1);
      rxd = 1'b1;
      repeat (40) @(negedge mclk);
      check("glitch_count", vcnt - v0, 32'd0);
      check("glitch_busy_lo", {31'd0, busy}, 32'h0);
      check("glitch_rdata", {24'd0, rdata}, 32'h80);

      // Back-to-back frames then a long break.
      baudrate = 16'd7;
      v0 = vcnt;
      send_frame(8'h00, 1'b0, 1'b0, 1'b1);
      send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
      rxd = 1'b0;
      repeat (240) @(negedge mclk);
      rxd = 1'b1;
      repeat (40) @(negedge mclk);
      check("b2b_count", vcnt - v0, 32'd3);
      check("b2b_first", {24'd0, log_data[v0]}, 32'h00);
      check("b2b_second", {24'd0, log_data[v0+1]}, 32'hFF);
      check("b2b_ferr", {31'd0, log_ferr[v0+1]}, 32'h0);
      check("break_data", {24'd0, log_data[v0+2]}, 32'h00);
      check("break_ferr", {31'd0, log_ferr[v0+2]}, 32'h1);
      check("break_busy", {31'd0, busy}, 32'h0);

      // Reset in the middle of data bit 4 of 0x5A.
      baudrate = 16'd15;
      v0 = vcnt;
      drive_bit(1'b0);
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      drive_bit(1'b1);
      rxd = 1'b1;
      repeat (8) @(negedge mclk);
      n_reset = 1'b0;
      repeat (2) @(negedge mclk);
      check("mrst_rdata", {24'd0, rdata}, 32'h0);
      check("mrst_ferr", {31'd0, frame_err}, 32'h0);
      check("mrst_busy", {31'd0, busy}, 32'h0);
      check("mrst_valid", {31'd0, rx_valid}, 32'h0);
      check("mrst_count", vcnt - v0, 32'd0);
      n_reset = 1'b1;
      repeat (10) @(negedge mclk);
      v0 = vcnt;
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
      repeat (20) @(negedge mclk);
      check("post_count", vcnt - v0, 32'd1);
      check("post_data", {24'd0, log_data[v0]}, 32'h5A);
      check("post_ferr", {31'd0, log_ferr[v0]}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
